fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin write-port arbiter that lets several producers share one synchronous FIFO's single write port. It sits directly in front of the FIFO. It grants one requester at a time for a bounded burst and forwards that requester's data to the FIFO's `write`/`data_in`. Write strobes are withheld while the FIFO reports `full`. Each requester receives a per-beat acknowledge so it can advance its own data.

## Interface
- `width`, 4: data word width; matches the FIFO `width`.
- `nreq`, 4: number of requesters; must be at least 2.
- `max_burst`, 4: maximum number of accepted words per grant; must be at least 1.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  nreq  per-requester write request; level, held until the word is acked.
- `req_data`  in  nreq*width  packed request data; requester i occupies bits [i*width +: width]; must be stable while `req[i]` is high.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_write`  out  1  write strobe to the FIFO.
- `fifo_data`  out  width  data to the FIFO `data_in`.
- `ack`  out  nreq  one-hot; `ack[i]`=1 means requester i's word is written this cycle.
- `grant`  out  nreq  registered one-hot current owner; all zeros when idle.
- `busy`  out  1  high whenever a grant is held.

## Operation
- Registered state:
  - `state` ∈ {IDLE, OWN}.
  - `grant` (one-hot).
  - `ptr` (priority pointer, range 0..nreq-1).
  - `cnt` (beats accepted in the current burst, width clog2(max_burst+1)).
- IDLE:
  - If any `req` bit is set, select the first set bit scanning upward from `ptr` and wrapping from nreq-1 to 0.
  - Load `grant` with the selected bit, clear `cnt`, and go to OWN.
  - Otherwise remain in IDLE.
- OWN, with owner o:
  - Combinational `fifo_write` = `req[o]` & ~`fifo_full`.
  - `fifo_data` = `req_data` slice o. `ack[o]` = `fifo_write`; all other ack bits are 0.
  - On a write: `cnt` <= `cnt`+1. If `cnt`+1 == max_burst, release.
  - On a cycle with `fifo_full`=1 and `req[o]`=1: stall. No write, `cnt` holds, and the grant is held.
  - On a cycle with `req[o]`=0: release immediately, with no write that cycle.
- Release:
  - `grant` <= 0, `state` <= IDLE.
  - `ptr` <= (o+1) mod nreq, so wrap-around from nreq-1 goes to 0.
  - `cnt` <= 0.
- When idle (`grant`=0), `fifo_data` is 0.
- `busy` = (`state`==OWN).
- No requester waits more than (nreq-1) × (max_burst+1) cycles plus FIFO-full stall time before being granted.

## Timing
- Reset (`rst_n`=0), asynchronous and effective immediately, including mid-burst:
  - `state`=IDLE, `grant`=0, `ptr`=0, `cnt`=0.
  - Outputs: `fifo_write`=0, `ack`=0, `fifo_data`=0, `busy`=0.
- Arbitration latency: request seen in IDLE at edge N; `grant` is valid from edge N+1. The first write can occur in cycle N+1.
- Full burst with no stalls:
  - Writes occur in cycles N+1 .. N+max_burst.
  - IDLE in cycle N+max_burst+1, a one-cycle bubble with no write.
  - Next grant from N+max_burst+2.
- `ack` and `fifo_write` are combinational from registered state, `req`, and `fifo_full`. They are valid in the same cycle and sampled by the FIFO and the requester at the next edge.
- The FIFO contract is one write per cycle maximum. `fifo_write` is never asserted while `fifo_full`=1.
- Simultaneous events:
  - `req[o]` falling in the same cycle as the last permitted beat is not possible; a write requires `req[o]`=1.
  - If `fifo_full`=1 and `req[o]` falls in the same cycle, release takes precedence.
- Requests arriving during OWN are ignored until the next IDLE cycle.

## Test plan
- Reset: drive `rst_n`=0 with `req`=4'b1111 and `fifo_full`=0 → `grant`=0, `fifo_write`=0, `ack`=0, `busy`=0. After `rst_n` rises, the first grant is 4'b0001.
- Single requester: `req[1]`=1 held with data 4'hA, `fifo_full`=0, from cycle 0 →
  - `grant`=4'b0010 in cycles 1–4 and `fifo_data`=4'hA.
  - `ack[1]`=1 for exactly 4 cycles, then `busy`=0 in cycle 5.
  - Re-grant to requester 1 in cycle 6.
- Round-robin with all four requesting continuously (data 4'h1, 4'h2, 4'h3, 4'h4) → owners 0, 1, 2, 3, 0 in order. Each owner gets 4 writes, separated by one idle cycle; FIFO receives 1,1,1,1,2,2,2,2,….
- Full stall: requester 2 granted, `fifo_full`=1 during burst cycles 2–3 → no `fifo_write` or `ack` in those cycles. `cnt` holds, the burst still delivers exactly 4 writes, and it ends 2 cycles later than unstalled.
- Early release: requester 3 drops `req` after 2 acks while 0 and 1 are requesting → grant releases, then `ptr` wraps to 0 and requester 0 is granted next.
- Reset mid-burst: assert `rst_n`=0 after 2 beats of requester 2 → `fifo_write`, `ack`, and `grant` go to 0 immediately. After release with `req`=4'b0110, requester 1 is granted first.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin owner of a shared FIFO write port.
// One requester holds the port for up to max_burst accepted words, then the
// port returns to IDLE for one cycle and the priority pointer moves past the
// previous owner so every requester is eventually served.
module fifo_write_arbiter #(
    parameter int width     = 4,
    parameter int nreq      = 4,
    parameter int max_burst = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [nreq-1:0]       req,
    input  logic [nreq*width-1:0] req_data,
    input  logic                  fifo_full,
    output logic                  fifo_write,
    output logic [width-1:0]      fifo_data,
    output logic [nreq-1:0]       ack,
    output logic [nreq-1:0]       grant,
    output logic                  busy
);

    localparam int PW = (nreq > 1) ? $clog2(nreq) : 1;
    localparam int CW = $clog2(max_burst + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(max_burst);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [nreq-1:0] grant_q, grant_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [PW-1:0]   owner_idx;
    logic            owner_req;
    logic [nreq-1:0] sel_onehot;
    logic            sel_found;
    logic [CW-1:0]   cnt_inc;
    logic [width-1:0] masked_data [nreq];

    // Each requester's word is gated by its own grant bit so the OR below is
    // a clean one-hot mux that yields zero when nobody owns the port.
    for (genvar gi = 0; gi < nreq; gi++) begin : g_mask
        assign masked_data[gi] = req_data[gi*width +: width] & {width{grant_q[gi]}};
    end

    // Combine the gated words into the FIFO data bus.
    always_comb begin
        fifo_data = '0;
        for (int i = 0; i < nreq; i++) begin
            fifo_data = fifo_data | masked_data[i];
        end
    end

    // Binary index of the current owner, used to advance the pointer.
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < nreq; i++) begin
            if (grant_q[i]) begin
                owner_idx = PW'(i);
            end
        end
    end

    // First requesting bit at or above ptr, wrapping past nreq-1 back to 0.
    always_comb begin
        sel_onehot = '0;
        sel_found  = 1'b0;
        for (int k = 0; k < nreq; k++) begin
            if (!sel_found && req[(int'(ptr_q) + k) % nreq]) begin
                sel_onehot[(int'(ptr_q) + k) % nreq] = 1'b1;
                sel_found = 1'b1;
            end
        end
    end

    assign owner_req  = |(grant_q & req);
    assign fifo_write = (state_q == OWN) && owner_req && !fifo_full;
    assign ack        = grant_q & req & {nreq{fifo_write}};
    assign grant      = grant_q;
    assign busy       = (state_q == OWN);
    assign cnt_inc    = cnt_q + CW'(1);

    // Next-state logic: arbitrate in IDLE, count beats or release in OWN.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d = sel_onehot;
                    cnt_d   = '0;
                    state_d = OWN;
                end
            end
            OWN: begin
                // A dropped request releases even if the FIFO is also full.
                if (!owner_req || (!fifo_full && (cnt_inc == MAX_CNT))) begin
                    grant_d = '0;
                    state_d = IDLE;
                    ptr_d   = PW'((int'(owner_idx) + 1) % nreq);
                    cnt_d   = '0;
                end else if (!fifo_full) begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed stimulus pushes expected FIFO writes
// into a queue; a monitor pops and compares on every observed write strobe.
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'b1111;
    logic [15:0] req_data = 16'h4321;
    logic        fifo_full = 1'b0;
    logic        fifo_write;
    logic [3:0]  fifo_data;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] data;
    } exp_t;
    exp_t exp_q[$];

    fifo_write_arbiter #(.width(4), .nreq(4), .max_burst(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .fifo_full (fifo_full),
        .fifo_write(fifo_write),
        .fifo_data (fifo_data),
        .ack       (ack),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_burst(input logic [1:0] id, input logic [3:0] data, input int n);
        exp_t e;
        e.id = id;
        e.data = data;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic begin_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    // Ends in the first cycle after reset release; caller drives req there.
    task automatic do_reset();
        begin_cycle();
        rst_n = 1'b0;
        req = 4'b0000;
        fifo_full = 1'b0;
        begin_cycle();
        rst_n = 1'b1;
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (fifo_write) begin
            exp_t e;
            vectors++;
            if (fifo_full) begin
                miscompares++;
                $display("FAIL write_while_full: fifo_write=1 with fifo_full=1 at %0t", $time);
            end else if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: data=%h ack=%b at %0t", fifo_data, ack, $time);
            end else begin
                e = exp_q.pop_front();
                if (fifo_data !== e.data || ack !== (4'b0001 << e.id)) begin
                    miscompares++;
                    $display("FAIL write_data: got data=%h ack=%b expected data=%h ack=%b at %0t",
                             fifo_data, ack, e.data, 4'b0001 << e.id, $time);
                end else begin
                    $display("write ok: requester %0d data=%h at %0t", e.id, fifo_data, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with every requester asking.
        repeat (2) begin_cycle();
        mid();
        check("rst_grant", grant, 4'b0000);
        check("rst_write", fifo_write, 1'b0);
        check("rst_ack", ack, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_data", fifo_data, 4'h0);

        // Release reset; round-robin 0,1,2,3,0 with one-cycle bubbles.
        begin_cycle();
        rst_n = 1'b1;
        push_burst(2'd0, 4'h1, 4);
        push_burst(2'd1, 4'h2, 4);
        push_burst(2'd2, 4'h3, 4);
        push_burst(2'd3, 4'h4, 4);
        push_burst(2'd0, 4'h1, 4);
        for (int c = 1; c <= 25; c++) begin
            begin_cycle();
            if (c == 25) req = 4'b0000;
            mid();
            if (((c - 1) % 5) < 4) begin
                check("rr_grant", grant, 4'b0001 << (((c - 1) / 5) % 4));
                check("rr_busy", busy, 1'b1);
            end else begin
                check("rr_bubble_grant", grant, 4'b0000);
                check("rr_bubble_busy", busy, 1'b0);
            end
        end
        check("rr_drain", exp_q.size(), 0);

        // Single requester 1 with data A: burst, bubble, re-grant.
        do_reset();
        req_data = 16'h00A0;
        req = 4'b0010;
        push_burst(2'd1, 4'hA, 5);
        for (int c = 1; c <= 7; c++) begin
            begin_cycle();
            if (c == 7) req = 4'b0000;
            mid();
            if (c <= 4) begin
                check("single_grant", grant, 4'b0010);
                check("single_ack", ack, 4'b0010);
                check("single_data", fifo_data, 4'hA);
            end else if (c == 5) begin
                check("single_bubble_busy", busy, 1'b0);
                check("single_bubble_ack", ack, 4'b0000);
                check("single_bubble_data", fifo_data, 4'h0);
            end else if (c == 6) begin
                check("single_regrant", grant, 4'b0010);
            end else begin
                check("single_drop_write", fifo_write, 1'b0);
            end
        end
        check("single_drain", exp_q.size(), 0);

        // Requester 2 with FIFO full in burst cycles 2-3.
        do_reset();
        req_data = 16'h0C00;
        req = 4'b0100;
        push_burst(2'd2, 4'hC, 4);
        for (int c = 1; c <= 7; c++) begin
            begin_cycle();
            fifo_full = (c == 2 || c == 3);
            if (c == 7) req = 4'b0000;
            mid();
            check("stall_write", fifo_write, (c == 1 || c >= 4 && c <= 6));
            check("stall_ack", ack, (c == 1 || c >= 4 && c <= 6) ? 4'b0100 : 4'b0000);
            check("stall_grant", grant, (c <= 6) ? 4'b0100 : 4'b0000);
        end
        check("stall_drain", exp_q.size(), 0);

        // Requester 3 drops after 2 acks; pointer wraps so 0 wins over 1.
        do_reset();
        req_data = 16'hD021;
        req = 4'b1000;
        push_burst(2'd3, 4'hD, 2);
        begin_cycle();
        req = 4'b1011;
        mid();
        check("early_grant3", grant, 4'b1000);
        begin_cycle();
        mid();
        check("early_write2", fifo_write, 1'b1);
        begin_cycle();
        req = 4'b0011;
        mid();
        check("early_drop_write", fifo_write, 1'b0);
        begin_cycle();
        mid();
        check("early_idle_busy", busy, 1'b0);
        push_burst(2'd0, 4'h1, 1);
        begin_cycle();
        mid();
        check("early_wrap_grant", grant, 4'b0001);
        check("early_drain", exp_q.size(), 0);

        // Reset mid-burst after 2 beats of requester 2.
        do_reset();
        req_data = 16'h0750;
        req = 4'b0100;
        push_burst(2'd2, 4'h7, 2);
        for (int c = 1; c <= 2; c++) begin
            begin_cycle();
            mid();
            check("mid_grant", grant, 4'b0100);
        end
        begin_cycle();
        rst_n = 1'b0;
        req = 4'b0110;
        #1;
        check("mid_rst_write", fifo_write, 1'b0);
        check("mid_rst_ack", ack, 4'b0000);
        check("mid_rst_grant", grant, 4'b0000);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_data", fifo_data, 4'h0);
        begin_cycle();
        rst_n = 1'b1;
        mid();
        check("mid_idle_grant", grant, 4'b0000);
        push_burst(2'd1, 4'h5, 1);
        begin_cycle();
        mid();
        check("mid_first_grant", grant, 4'b0010);
        check("mid_first_data", fifo_data, 4'h5);
        begin_cycle();
        rst_n = 1'b0;
        req = 4'b0000;
        begin_cycle();
        rst_n = 1'b1;
        mid();
        check("final_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
